bram_copy_engine: RTL and testbench
===================================

// Module: bram_copy_engine
// PURPOSE
//  Memory-to-memory copy initiator. Drives the single-cycle-pulse request/ready protocol of the BRAM blocks from the master side.
//  Reads N words through a read port and writes them through a write port, one word in flight at a time.
//  Sits between a control register block (start/addresses/count) and any 1r1w BRAM or compatible responder.
// PARAMETERS
//  WIDTH        32       data word width, matches the responder
//  ADDR_LSH     2        byte-address shift; address stride per word = 1 << ADDR_LSH
//  COUNT_WIDTH  16       width of the word-count input
//  TIMEOUT      256      max cycles waiting for ready per transaction; 0 disables watchdog
// PORTS
//  i_clock         in   1            clock, rising edge
//  i_reset_n       in   1            asynchronous active-low reset
//  i_start         in   1            start pulse; sampled only in IDLE
//  i_src_address   in   32           source byte address, latched on start
//  i_dst_address   in   32           destination byte address, latched on start
//  i_count         in   COUNT_WIDTH  words to copy, latched on start
//  o_busy          out  1            high from cycle after accepted start until return to IDLE
//  o_done          out  1            single-cycle pulse on completion (success or error)
//  o_error         out  1            sticky timeout flag, cleared by next accepted start
//  o_rd_request    out  1            read request pulse
//  o_rd_address    out  32           read byte address, stable from request until ready
//  i_rd_rdata      in   WIDTH        read data, valid when i_rd_ready
//  i_rd_ready      in   1            read completion
//  o_wr_request    out  1            write request pulse
//  o_wr_address    out  32           write byte address, stable from request until ready
//  o_wr_wdata      out  WIDTH        write data, stable from request until ready
//  i_wr_ready      in   1            write completion
// BEHAVIOUR
//  - Reset: state IDLE; o_busy, o_done, o_error, o_rd_request, o_wr_request = 0; addresses and wdata = 0.
//  - Protocol: request is a registered 1-cycle pulse; address/wdata are held until the matching ready is sampled high.
//    Ready is honoured only in the WAIT states. Ready seen in any other state is ignored, including stale ready after reset.
//  - FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | IDLE); ERROR_EXIT -> IDLE.
//    IDLE: on i_start, latch src/dst/count and clear o_error. count==0 -> stay IDLE with o_done pulsed next cycle, no requests issued.
//      Otherwise go to RD_REQ.
//    RD_REQ: o_rd_request=1 for this cycle; o_rd_address = src.
//    RD_WAIT: on i_rd_ready, capture i_rd_rdata into o_wr_wdata -> WR_REQ.
//    WR_REQ: o_wr_request=1; o_wr_address = dst.
//    WR_WAIT: on i_wr_ready: src += stride, dst += stride, remaining -= 1. remaining==0 -> IDLE with o_done=1, else RD_REQ.
//  - Address arithmetic: 32-bit unsigned; wraps 0xFFFFFFFC -> 0x00000000 silently.
//  - Latency: zero-wait responder = 4 cycles/word. o_done is high in the cycle after edge 4N, counted from the start edge.
//  - Watchdog: counter reset on entering each WAIT state. If it reaches TIMEOUT with no ready:
//    go to ERROR_EXIT, set o_error, then IDLE with o_done pulse. Remaining words are abandoned.
//  - i_start while busy: ignored. A start in the o_done cycle (already IDLE) is accepted.
//  - Reset mid-transfer: immediate abort to IDLE; no o_done pulse; the partial copy is left as-is.
// CONFIGURATION
//  BRAM_COPY_FILL_EN defined: extra ports i_fill (1) and i_fill_data (WIDTH), latched on start.
//    When i_fill=1, RD_REQ/RD_WAIT are skipped and o_wr_wdata = fill_data: 2 cycles/word, o_rd_request never asserted.
//  Not defined: ports absent, always copy.
// STRUCTURE
//  Package bram_copy_pkg: state_t enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ERROR_EXIT).
//    Also localparam-style function stride(ADDR_LSH) returning 32'(1) << ADDR_LSH.
//  One sub-module: bram_copy_watchdog (enable/clear in, timeout pulse out, TIMEOUT param; tied off when TIMEOUT==0).
// TESTING (bench uses a BRAM_1r1w-compatible responder with optional wait-state injection)
//  1. src=0x000, dst=0x100, count=4, src words 0x11..0x44:
//     dst words 0x40..0x43 = 0x11..0x44; o_done 16 cycles after start; o_error=0.
//  2. count=0: o_done next cycle; no o_rd_request/o_wr_request ever asserted.
//  3. Responder adds 3 wait cycles per access, count=2: data correct.
//     Each address held stable through its wait; o_done at cycle 2*(4+6) after start.
//  4. TIMEOUT=8, read ready withheld: o_error=1 and o_done pulse 8 cycles after RD_WAIT entry.
//     Next start clears o_error.
//  5. i_reset_n low during WR_WAIT of word 1, then a stale i_wr_ready:
//     all outputs 0, stays IDLE, no o_done.
//     i_start held high throughout the busy period: exactly one transfer.
//  6. BRAM_COPY_FILL_EN, i_fill=1, i_fill_data=0xDEADBEEF, dst=0xFFFFFFF8, count=3:
//     writes to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; o_done at 6 cycles; no reads.

Source files
------------

// File: rtl/bram_copy_pkg.sv
// Shared types and helpers for the BRAM copy engine.
//   state_t : copy FSM states
//   stride  : byte-address increment per word for a given address shift
package bram_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ERROR_EXIT
    } state_t;

    function automatic logic [31:0] stride(input int unsigned addr_lsh);
        return 32'(1) << addr_lsh;
    endfunction

endpackage

// File: rtl/bram_copy_watchdog.sv
// Per-transaction ready watchdog for the copy engine.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   enable  : high while the engine waits for a ready
//   clear   : restarts the count (asserted the cycle before a wait begins)
//   timeout : high in the TIMEOUT-th consecutive enabled cycle without clear
// TIMEOUT == 0 removes the counter and ties timeout low.
module bram_copy_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (enable && !timeout) begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            // count_reg holds the number of wait cycles already elapsed, so
            // the pulse lands in the TIMEOUT-th cycle of the wait.
            assign timeout = enable && (count_reg == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/bram_copy_engine.sv
// Memory-to-memory copy initiator using the single-cycle request / ready
// handshake of the BRAM blocks. One word in flight: read, then write.
// Ports:
//   i_clock, i_reset_n              : clock, asynchronous active-low reset
//   i_start, i_src_address,
//   i_dst_address, i_count          : job request, latched when accepted in IDLE
//   o_busy, o_done, o_error         : status (done = 1-cycle pulse, error sticky)
//   o_rd_request/o_rd_address,
//   i_rd_rdata/i_rd_ready           : read port (master side)
//   o_wr_request/o_wr_address,
//   o_wr_wdata/i_wr_ready           : write port (master side)
// Optional feature macro BRAM_COPY_FILL_EN adds i_fill / i_fill_data: a fill
// job skips the read phase and writes i_fill_data to every destination word.
module bram_copy_engine
    import bram_copy_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_LSH    = 2,
    parameter int COUNT_WIDTH = 16,
    parameter int TIMEOUT     = 256
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic [31:0]            i_src_address,
    input  logic [31:0]            i_dst_address,
    input  logic [COUNT_WIDTH-1:0] i_count,
`ifdef BRAM_COPY_FILL_EN
    input  logic                   i_fill,
    input  logic [WIDTH-1:0]       i_fill_data,
`endif
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_rd_request,
    output logic [31:0]            o_rd_address,
    input  logic [WIDTH-1:0]       i_rd_rdata,
    input  logic                   i_rd_ready,
    output logic                   o_wr_request,
    output logic [31:0]            o_wr_address,
    output logic [WIDTH-1:0]       o_wr_wdata,
    input  logic                   i_wr_ready
);

    localparam logic [31:0] STEP = stride(ADDR_LSH);

    state_t                 state_reg, state_next;
    logic [31:0]            src_reg, src_next;
    logic [31:0]            dst_reg, dst_next;
    logic [COUNT_WIDTH-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0]       wdata_reg, wdata_next;
    logic                   error_reg, error_next;
    logic                   done_reg, done_next;
    logic                   rd_request_reg, wr_request_reg;
    logic                   fill_active;
    logic                   timeout;

`ifdef BRAM_COPY_FILL_EN
    logic fill_reg, fill_next;
    assign fill_active = fill_reg;
`else
    assign fill_active = 1'b0;
`endif

    // The counter restarts in the request cycle so every wait starts at zero.
    bram_copy_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (i_clock),
        .rst_n   (i_reset_n),
        .enable  ((state_reg == RD_WAIT) || (state_reg == WR_WAIT)),
        .clear   ((state_reg == RD_REQ) || (state_reg == WR_REQ)),
        .timeout (timeout)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            remaining_reg  <= '0;
            wdata_reg      <= '0;
            error_reg      <= 1'b0;
            done_reg       <= 1'b0;
            rd_request_reg <= 1'b0;
            wr_request_reg <= 1'b0;
`ifdef BRAM_COPY_FILL_EN
            fill_reg       <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            remaining_reg  <= remaining_next;
            wdata_reg      <= wdata_next;
            error_reg      <= error_next;
            done_reg       <= done_next;
            // Request states last exactly one cycle, so these are 1-cycle pulses.
            rd_request_reg <= (state_next == RD_REQ);
            wr_request_reg <= (state_next == WR_REQ);
`ifdef BRAM_COPY_FILL_EN
            fill_reg       <= fill_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        remaining_next = remaining_reg;
        wdata_next     = wdata_reg;
        error_next     = error_reg;
        done_next      = 1'b0;
`ifdef BRAM_COPY_FILL_EN
        fill_next      = fill_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    src_next       = i_src_address;
                    dst_next       = i_dst_address;
                    remaining_next = i_count;
                    error_next     = 1'b0;
`ifdef BRAM_COPY_FILL_EN
                    fill_next      = i_fill;
`endif
                    if (i_count == '0) begin
                        done_next = 1'b1;
`ifdef BRAM_COPY_FILL_EN
                    end else if (i_fill) begin
                        wdata_next = i_fill_data;
                        state_next = WR_REQ;
`endif
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            RD_REQ: state_next = RD_WAIT;
            RD_WAIT: begin
                // Ready wins over a watchdog expiry in the same cycle.
                if (i_rd_ready) begin
                    wdata_next = i_rd_rdata;
                    state_next = WR_REQ;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = ERROR_EXIT;
                end
            end
            WR_REQ: state_next = WR_WAIT;
            WR_WAIT: begin
                if (i_wr_ready) begin
                    src_next       = src_reg + STEP;
                    dst_next       = dst_reg + STEP;
                    remaining_next = remaining_reg - COUNT_WIDTH'(1);
                    if (remaining_reg == COUNT_WIDTH'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (fill_active) begin
                        state_next = WR_REQ;
                    end else begin
                        state_next = RD_REQ;
                    end
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = ERROR_EXIT;
                end
            end
            ERROR_EXIT: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_busy       = (state_reg != IDLE);
    assign o_done       = done_reg;
    assign o_error      = error_reg;
    assign o_rd_request = rd_request_reg;
    assign o_rd_address = src_reg;
    assign o_wr_request = wr_request_reg;
    assign o_wr_address = dst_reg;
    assign o_wr_wdata   = wdata_reg;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Self-checking bench for bram_copy_engine with a BRAM-style responder
// (registered 1-cycle response, optional wait states, optional withheld read).
// Build with +define+BRAM_COPY_FILL_EN to also cover the fill feature.
module tb_bram_copy_engine;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [31:0]       src_address, dst_address;
    logic [15:0]       count;
    logic              busy, done, error;
    logic              rd_request, rd_ready, wr_request, wr_ready;
    logic [31:0]       rd_address, wr_address;
    logic [WIDTH-1:0]  rd_rdata, wr_wdata;
`ifdef BRAM_COPY_FILL_EN
    logic              fill;
    logic [WIDTH-1:0]  fill_data;
`endif

    always #5 clk = ~clk;

    bram_copy_engine #(
        .WIDTH(WIDTH), .ADDR_LSH(2), .COUNT_WIDTH(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
        .i_src_address(src_address), .i_dst_address(dst_address), .i_count(count),
`ifdef BRAM_COPY_FILL_EN
        .i_fill(fill), .i_fill_data(fill_data),
`endif
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_rd_request(rd_request), .o_rd_address(rd_address),
        .i_rd_rdata(rd_rdata), .i_rd_ready(rd_ready),
        .o_wr_request(wr_request), .o_wr_address(wr_address),
        .o_wr_wdata(wr_wdata), .i_wr_ready(wr_ready)
    );

    // ---------------- responder (source memory read-only, writes logged) ----
    logic [31:0] src_mem [0:255];
    int          wait_cycles = 0;
    bit          rd_block = 1'b0;
    bit          rd_pend = 1'b0, wr_pend = 1'b0;
    int          rd_left = 0, wr_left = 0;
    logic [31:0] rd_addr_q, wr_addr_q, wr_data_q;
    int          rd_req_seen = 0, wr_req_seen = 0, done_seen = 0, unstable = 0;
    int          cyc = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_ready <= 1'b0;
        wr_ready <= 1'b0;
        if (rd_request) begin
            rd_req_seen <= rd_req_seen + 1;
            if (rd_block) begin
                rd_pend <= 1'b0;
            end else if (wait_cycles == 0) begin
                rd_ready <= 1'b1;
                rd_rdata <= src_mem[widx(rd_address)];
                rd_pend  <= 1'b0;
            end else begin
                rd_pend   <= 1'b1;
                rd_left   <= wait_cycles - 1;
                rd_addr_q <= rd_address;
            end
        end else if (rd_pend) begin
            if (rd_address !== rd_addr_q) unstable <= unstable + 1;
            if (rd_left == 0) begin
                rd_ready <= 1'b1;
                rd_rdata <= src_mem[widx(rd_addr_q)];
                rd_pend  <= 1'b0;
            end else begin
                rd_left <= rd_left - 1;
            end
        end
        if (wr_request) begin
            wr_req_seen <= wr_req_seen + 1;
            if (wait_cycles == 0) begin
                wr_ready <= 1'b1;
                log_addr.push_back(wr_address);
                log_data.push_back(wr_wdata);
                $display("write transaction: addr=%h data=%h", wr_address, wr_wdata);
                wr_pend <= 1'b0;
            end else begin
                wr_pend   <= 1'b1;
                wr_left   <= wait_cycles - 1;
                wr_addr_q <= wr_address;
                wr_data_q <= wr_wdata;
            end
        end else if (wr_pend) begin
            if (wr_address !== wr_addr_q || wr_wdata !== wr_data_q) unstable <= unstable + 1;
            if (wr_left == 0) begin
                wr_ready <= 1'b1;
                log_addr.push_back(wr_addr_q);
                log_data.push_back(wr_data_q);
                $display("write transaction: addr=%h data=%h", wr_addr_q, wr_data_q);
                wr_pend <= 1'b0;
            end else begin
                wr_left <= wr_left - 1;
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

    // ---------------- bench bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit hold_start = 1'b0;

    // Starts a job: start is high for the edge following this call.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n,
                            output int start_edge);
        @(negedge clk);
        src_address = s;
        dst_address = d;
        count       = 16'(n);
        start       = 1'b1;
        start_edge  = cyc + 1;
    endtask

    task automatic wait_done(input int budget, output int done_edge, output bit ok);
        ok = 1'b0;
        done_edge = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (done === 1'b1) begin
                ok = 1'b1;
                done_edge = cyc;
                break;
            end
        end
    endtask

    // Expected write stream of a copy: word i of the source lands at dst + 4*i.
    task automatic check_copy(input string name, input int base, input logic [31:0] s,
                              input logic [31:0] d, input int n);
        int bad = 0;
        n_checks++;
        if (log_addr.size() - base != n) begin
            n_errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, log_addr.size() - base, n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [31:0] ea, ed;
            ea = d + 32'(4 * i);
            ed = src_mem[((s >> 2) + 32'(i)) & 32'hFF];
            if (log_addr[base + i] !== ea || log_data[base + i] !== ed) begin
                bad++;
                $display("FAIL %s word %0d: got %h@%h expected %h@%h", name, i,
                         log_data[base + i], log_addr[base + i], ed, ea);
            end
        end
        if (bad != 0) n_errors++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; src_address = '0; dst_address = '0; count = '0;
`ifdef BRAM_COPY_FILL_EN
        fill = 1'b0; fill_data = '0;
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, error, rd_request, wr_request} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset flags: got %b expected 00000", {busy, done, error, rd_request, wr_request});
        end
        n_checks++;
        if ({rd_address, wr_address, wr_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset buses: got %h %h %h expected zeros", rd_address, wr_address, wr_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int se, de, base, rd0; bit ok;
        for (int i = 0; i < 4; i++) src_mem[i] = 32'h11 * 32'(i + 1);
        wait_cycles = 0;
        base = log_addr.size(); rd0 = rd_req_seen;
        do_start(32'h0, 32'h100, 4, se);
        wait_done(200, de, ok);
        n_checks++;
        if (!ok || de - se != 16) begin
            n_errors++;
            $display("FAIL basic latency: got %0d expected 16 (done seen=%0d)", de - se, ok);
        end
        n_checks++;
        if (error !== 1'b0) begin n_errors++; $display("FAIL basic error: got %b expected 0", error); end
        check_copy("basic", base, 32'h0, 32'h100, 4);
        n_checks++;
        if (rd_req_seen - rd0 != 4) begin
            n_errors++; $display("FAIL basic reads: got %0d expected 4", rd_req_seen - rd0);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL basic done pulse width: got %b expected 0", done); end
    endtask

    task automatic test_zero_count();
        int se, de, rd0, wr0; bit ok;
        rd0 = rd_req_seen; wr0 = wr_req_seen;
        do_start(32'h40, 32'h80, 0, se);
        wait_done(20, de, ok);
        n_checks++;
        if (!ok || de - se != 0) begin
            n_errors++; $display("FAIL zero latency: got %0d expected 0 (done seen=%0d)", de - se, ok);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL zero busy: got %b expected 0", busy); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (rd_req_seen != rd0 || wr_req_seen != wr0) begin
            n_errors++;
            $display("FAIL zero requests: got rd=%0d wr=%0d expected 0 0", rd_req_seen - rd0, wr_req_seen - wr0);
        end
    endtask

    task automatic test_wait_states();
        int se, de, base, u0; bit ok;
        logic [31:0] s, d;
        s = 32'($urandom_range(0, 63)) << 2;
        d = 32'h200 + (32'($urandom_range(0, 63)) << 2);
        for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
        wait_cycles = 3;
        base = log_addr.size(); u0 = unstable;
        do_start(s, d, 2, se);
        wait_done(200, de, ok);
        n_checks++;
        if (!ok || de - se != 20) begin
            n_errors++; $display("FAIL wait latency: got %0d expected 20 (done seen=%0d)", de - se, ok);
        end
        check_copy("wait", base, s, d, 2);
        n_checks++;
        if (unstable != u0) begin
            n_errors++; $display("FAIL wait stability: got %0d unstable cycles expected 0", unstable - u0);
        end
        wait_cycles = 0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int se, de, base, w, n; bit ok;
            logic [31:0] s, d;
            w = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            s = {$urandom, 2'b00};
            d = {$urandom, 2'b00};
            wait_cycles = w;
            base = log_addr.size();
            do_start(s, d, n, se);
            wait_done(300, de, ok);
            n_checks++;
            if (!ok || de - se != n * (4 + 2 * w)) begin
                n_errors++;
                $display("FAIL random latency: got %0d expected %0d (n=%0d w=%0d)", de - se, n * (4 + 2 * w), n, w);
            end
            n_checks++;
            if (error !== 1'b0) begin n_errors++; $display("FAIL random error: got %b expected 0", error); end
            check_copy("random", base, s, d, n);
        end
        wait_cycles = 0;
    endtask

    task automatic test_timeout();
        int se, de, wr0, base; bit ok;
        rd_block = 1'b1;
        wr0 = wr_req_seen;
        do_start(32'h10, 32'h300, 3, se);
        wait_done(100, de, ok);
        // TIMEOUT cycles in RD_WAIT, one cycle in ERROR_EXIT, then done.
        n_checks++;
        if (!ok || de - se != TIMEOUT + 2) begin
            n_errors++; $display("FAIL timeout latency: got %0d expected %0d (done seen=%0d)", de - se, TIMEOUT + 2, ok);
        end
        n_checks++;
        if (error !== 1'b1) begin n_errors++; $display("FAIL timeout error flag: got %b expected 1", error); end
        rd_block = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || wr_req_seen != wr0) begin
            n_errors++; $display("FAIL timeout sticky: got error=%b writes=%0d expected 1 0", error, wr_req_seen - wr0);
        end
        base = log_addr.size();
        do_start(32'h20, 32'h340, 1, se);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (error !== 1'b0) begin n_errors++; $display("FAIL timeout clear: got %b expected 0", error); end
        wait_done(100, de, ok);
        n_checks++;
        if (!ok || de - se != 4 || error !== 1'b0) begin
            n_errors++; $display("FAIL timeout recovery: got latency %0d error %b expected 4 0", de - se, error);
        end
        check_copy("recovery", base, 32'h20, 32'h340, 1);
    endtask

    task automatic test_back_to_back();
        int se, de, base, wr0; bit ok;
        wait_cycles = 0;
        base = log_addr.size(); wr0 = wr_req_seen;
        hold_start = 1'b1;
        do_start(32'h80, 32'h3C0, 3, se);
        wait_done(200, de, ok);
        n_checks++;
        if (!ok || wr_req_seen - wr0 != 3) begin
            n_errors++; $display("FAIL held start: got %0d writes expected 3 (done seen=%0d)", wr_req_seen - wr0, ok);
        end
        check_copy("held", base, 32'h80, 32'h3C0, 3);
        // Still in the done cycle: a start here must be accepted.
        base = log_addr.size();
        src_address = 32'hA0; dst_address = 32'h1E0; count = 16'd2;
        se = cyc + 1;
        hold_start = 1'b0;
        wait_done(200, de, ok);
        n_checks++;
        if (!ok || de - se != 8) begin
            n_errors++; $display("FAIL done-cycle start latency: got %0d expected 8 (done seen=%0d)", de - se, ok);
        end
        check_copy("done-cycle", base, 32'hA0, 32'h1E0, 2);
    endtask

    task automatic test_reset_mid();
        int se, wr0, d0, k; bit hit;
        wait_cycles = 3;
        wr0 = wr_req_seen;
        do_start(32'h0, 32'h100, 4, se);
        hit = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_request === 1'b1 && wr_req_seen - wr0 == 1) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin n_errors++; $display("FAIL reset-mid: second write request not seen within 200 cycles"); end
        @(negedge clk);                 // now in WR_WAIT of word 1
        d0 = done_seen;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, error, rd_request, wr_request} !== 5'b0 || {rd_address, wr_address, wr_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset-mid outputs: got flags %b buses %h %h %h expected zeros",
                     {busy, done, error, rd_request, wr_request}, rd_address, wr_address, wr_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({busy, done, rd_request, wr_request} !== 4'b0) hit = 1'b1;
        end
        n_checks++;
        if (hit || done_seen != d0) begin
            n_errors++; $display("FAIL reset-mid idle: got activity=%b done pulses=%0d expected 0 0", hit, done_seen - d0);
        end
        wait_cycles = 0;
    endtask

`ifdef BRAM_COPY_FILL_EN
    task automatic test_fill();
        int se, de, base, rd0, bad; bit ok;
        logic [31:0] ea;
        wait_cycles = 0;
        fill = 1'b1; fill_data = 32'hDEADBEEF;
        base = log_addr.size(); rd0 = rd_req_seen;
        do_start(32'h0, 32'hFFFFFFF8, 3, se);
        wait_done(100, de, ok);
        fill = 1'b0;
        n_checks++;
        if (!ok || de - se != 6) begin
            n_errors++; $display("FAIL fill latency: got %0d expected 6 (done seen=%0d)", de - se, ok);
        end
        n_checks++;
        if (rd_req_seen != rd0) begin n_errors++; $display("FAIL fill reads: got %0d expected 0", rd_req_seen - rd0); end
        n_checks++;
        bad = 0;
        if (log_addr.size() - base != 3) bad = 1;
        else for (int i = 0; i < 3; i++) begin
            ea = 32'hFFFFFFF8 + 32'(4 * i);
            if (log_addr[base + i] !== ea || log_data[base + i] !== 32'hDEADBEEF) bad++;
        end
        if (bad != 0) begin
            n_errors++; $display("FAIL fill writes: got %0d bad of %0d expected 0 bad of 3", bad, log_addr.size() - base);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wait_states();
        test_random();
        test_timeout();
        test_back_to_back();
`ifdef BRAM_COPY_FILL_EN
        test_fill();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

endmodule
